// File: rtl/axi_read_slave.sv
// rtl/axi_read_slave.sv - AXI4 read-channel responder with FIXED/INCR/WRAP beat addressing
//
// Accepts one AR request at a time. Each beat is fetched from a synchronous
// one-cycle-latency memory port, captured, and presented on R until rready.
// Illegal requests (reserved burst, oversize beat, bad WRAP length) are
// answered with arlen+1 SLVERR beats and never touch the memory.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   s_axi_ar*            read address channel (slave side)
//   s_axi_r*             read data channel (slave side)
//   mem_en, mem_addr     memory read strobe and byte address
//   mem_rdata            memory data, valid the cycle after mem_en
module axi_read_slave #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic [AW-1:0]  s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [IDW-1:0] s_axi_rid,
  output logic [DW-1:0]  s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  output logic           mem_en,
  output logic [AW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_rdata
);

  localparam logic [2:0]    SZ_MAX = 3'($clog2(DW / 8));
  localparam logic [AW-1:0] ONE    = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_RESP,
    S_ERR
  } state_t;

  state_t           state_q;
  logic             arready_q;
  logic             rvalid_q;
  logic             rlast_q;
  logic [1:0]       rresp_q;
  logic [IDW-1:0]   rid_q;
  logic [DW-1:0]    rdata_q;
  logic             mem_en_q;
  logic [AW-1:0]    mem_addr_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       len_q;
  logic [2:0]       size_q;
  logic [1:0]       burst_q;
  logic [7:0]       cnt_q;

  logic             ar_fire;
  logic             wrap_len_ok;
  logic             req_err;
  logic             last_beat;
  logic [AW-1:0]    beat_bytes;
  logic [AW-1:0]    wrap_bytes;
  logic [AW-1:0]    addr_d;

  assign ar_fire   = s_axi_arvalid & arready_q;
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                  (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
    req_err     = (s_axi_arburst == 2'b11) ||
                  (s_axi_arsize > SZ_MAX) ||
                  ((s_axi_arburst == 2'b10) && !wrap_len_ok);
  end

  // Next beat address. INCR realigns after the first (possibly unaligned)
  // beat; WRAP keeps the upper bits of the wrap window and increments within it.
  always_comb begin
    beat_bytes = ONE << size_q;
    wrap_bytes = (AW'(len_q) + ONE) << size_q;
    case (burst_q)
      2'b00:   addr_d = addr_q;
      2'b10:   addr_d = (addr_q & ~(wrap_bytes - ONE)) |
                        ((addr_q + beat_bytes) & (wrap_bytes - ONE));
      default: addr_d = (addr_q & ~(beat_bytes - ONE)) + beat_bytes;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
      rid_q      <= '0;
      rdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
    end else begin
      // mem_en is a single-cycle strobe, raised only on entry to FETCH.
      mem_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ar_fire) begin
            arready_q <= 1'b0;
            rid_q     <= s_axi_arid;
            addr_q    <= s_axi_araddr;
            len_q     <= s_axi_arlen;
            size_q    <= s_axi_arsize;
            burst_q   <= s_axi_arburst;
            cnt_q     <= '0;
            if (req_err) begin
              state_q  <= S_ERR;
              rvalid_q <= 1'b1;
              rresp_q  <= 2'b10;
              rdata_q  <= '0;
              rlast_q  <= (s_axi_arlen == 8'd0);
            end else begin
              state_q    <= S_FETCH;
              mem_en_q   <= 1'b1;
              mem_addr_q <= s_axi_araddr;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rdata_q  <= mem_rdata;
          rvalid_q <= 1'b1;
          rresp_q  <= 2'b00;
          rlast_q  <= last_beat;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          if (s_axi_rready) begin
            cnt_q    <= cnt_q + 8'd1;
            addr_q   <= addr_d;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (last_beat) begin
              state_q   <= S_IDLE;
              arready_q <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              mem_en_q   <= 1'b1;
              mem_addr_q <= addr_d;
            end
          end
        end
        S_ERR: begin
          if (s_axi_rready) begin
            cnt_q <= cnt_q + 8'd1;
            if (last_beat) begin
              state_q   <= S_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              rlast_q <= ((cnt_q + 8'd1) == len_q);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign mem_en        = mem_en_q;
  assign mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// tb/tb_axi_read_slave.sv - directed bench for axi_read_slave
module tb_axi_read_slave;

  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           resetn;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic           mem_en;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  axi_read_slave #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  // Synchronous memory: data for the strobed address appears next cycle.
  always @(posedge clk) if (mem_en) mem_rdata <= pat(mem_addr);

  typedef struct {
    logic [11:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  int tests = 0;
  int fails = 0;

  req_t        req_q[$];
  logic [63:0] b_data[$];
  logic        b_last[$];
  logic [11:0] b_id[$];
  logic [1:0]  b_resp[$];
  int          b_n[$];
  int          hs_n[$];
  logic [31:0] m_addr[$];
  logic [63:0] st_data[$];
  logic        st_last[$];
  logic [11:0] st_id[$];
  logic        st_valid[$];
  int          ar_back_n;
  bit          timed_out;

  logic [31:0] e_addr[$];
  logic [11:0] e_id[$];
  logic        e_last[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    req_t r;
    r.id = id; r.addr = addr; r.len = len; r.size = size; r.burst = burst;
    req_q.push_back(r);
  endtask

  task automatic drive_front;
    arid = req_q[0].id; araddr = req_q[0].addr; arlen = req_q[0].len;
    arsize = req_q[0].size; arburst = req_q[0].burst; arvalid = 1'b1;
  endtask

  // Read master: issues queued requests in order, consumes R beats, optionally
  // stalls one beat or asserts reset when a given beat appears. Called at a negedge.
  task automatic run(input int exp_beats, input int stall_beat, input int stall_len, input int abort_at);
    int  n = 0;
    bit  hs_pend = 0;
    int  stall_left = stall_len;
    b_data.delete(); b_last.delete(); b_id.delete(); b_resp.delete(); b_n.delete();
    hs_n.delete(); m_addr.delete();
    st_data.delete(); st_last.delete(); st_id.delete(); st_valid.delete();
    timed_out = 0; ar_back_n = -1; rready = 1'b1;
    if (req_q.size() > 0) drive_front();
    for (int it = 0; it < 400; it++) begin
      if (mem_en) m_addr.push_back(mem_addr);
      if (hs_pend) begin
        hs_pend = 0;
        void'(req_q.pop_front());
        if (req_q.size() > 0) drive_front(); else arvalid = 1'b0;
      end
      if (arvalid && arready) begin
        hs_n.push_back(n);
        hs_pend = 1;
      end
      if (rvalid) begin
        if (abort_at >= 0 && b_data.size() == abort_at) begin
          resetn = 1'b0;
          return;
        end
        if (b_data.size() == stall_beat && stall_left > 0) begin
          rready = 1'b0;
          stall_left--;
          st_data.push_back(rdata); st_last.push_back(rlast);
          st_id.push_back(rid); st_valid.push_back(rvalid);
        end else begin
          rready = 1'b1;
          b_data.push_back(rdata); b_last.push_back(rlast);
          b_id.push_back(rid); b_resp.push_back(rresp); b_n.push_back(n);
        end
      end else begin
        rready = 1'b1;
      end
      if (b_data.size() >= exp_beats && req_q.size() == 0 && !hs_pend && arready && !rvalid) begin
        ar_back_n = n;
        return;
      end
      @(negedge clk);
      n++;
    end
    timed_out = 1;
    arvalid = 1'b0;
    req_q.delete();
  endtask

  task automatic check_ok(input string tag);
    chk({tag, "_done"}, 64'(timed_out), 64'd0);
    chk({tag, "_beats"}, 64'(b_data.size()), 64'(e_addr.size()));
    chk({tag, "_mem_pulses"}, 64'(m_addr.size()), 64'(e_addr.size()));
    for (int i = 0; i < e_addr.size(); i++) begin
      chk($sformatf("%s_mem_addr%0d", tag, i), 64'(m_addr[i]), 64'(e_addr[i]));
      chk($sformatf("%s_rdata%0d", tag, i), b_data[i], pat(e_addr[i]));
      chk($sformatf("%s_rid%0d", tag, i), 64'(b_id[i]), 64'(e_id[i]));
      chk($sformatf("%s_rlast%0d", tag, i), 64'(b_last[i]), 64'(e_last[i]));
      chk($sformatf("%s_rresp%0d", tag, i), 64'(b_resp[i]), 64'd0);
    end
  endtask

  task automatic check_err(input string tag, input logic [11:0] id);
    chk({tag, "_done"}, 64'(timed_out), 64'd0);
    chk({tag, "_beats"}, 64'(b_data.size()), 64'd3);
    chk({tag, "_mem_pulses"}, 64'(m_addr.size()), 64'd0);
    chk({tag, "_first_lat"}, 64'(b_n[0] - hs_n[0]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_rresp%0d", tag, i), 64'(b_resp[i]), 64'd2);
      chk($sformatf("%s_rdata%0d", tag, i), b_data[i], 64'd0);
      chk($sformatf("%s_rid%0d", tag, i), 64'(b_id[i]), 64'(id));
      chk($sformatf("%s_rlast%0d", tag, i), 64'(b_last[i]), (i == 2) ? 64'd1 : 64'd0);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 64'(b_n[i] - b_n[i-1]), 64'd1);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_arready"}, 64'(arready), 64'd0);
    chk({tag, "_rvalid_rlast_rresp"}, 64'({rvalid, rlast, rresp}), 64'd0);
    chk({tag, "_rid"}, 64'(rid), 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_mem"}, 64'({mem_en, mem_addr}), 64'd0);
  endtask

  initial begin
    bit quiet;
    resetn = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
    arsize = '0; arburst = '0; rready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("arready_after_reset", 64'(arready), 64'd1);

    // INCR, aligned, with latency and arready-return timing.
    push_req(12'h001, 32'h100, 8'd3, 3'd3, 2'b01);
    run(4, -1, 0, -1);
    e_addr = '{32'h100, 32'h108, 32'h110, 32'h118};
    e_id   = '{12'h001, 12'h001, 12'h001, 12'h001};
    e_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_ok("incr");
    chk("incr_first_lat", 64'(b_n[0] - hs_n[0]), 64'd3);
    for (int i = 1; i < 4; i++) chk($sformatf("incr_gap%0d", i), 64'(b_n[i] - b_n[i-1]), 64'd3);
    chk("incr_arready_back", 64'(ar_back_n - b_n[3]), 64'd1);

    // WRAP within a 16-byte window.
    push_req(12'hABC, 32'h1C, 8'd3, 3'd2, 2'b10);
    run(4, -1, 0, -1);
    e_addr = '{32'h1C, 32'h10, 32'h14, 32'h18};
    e_id   = '{12'hABC, 12'hABC, 12'hABC, 12'hABC};
    e_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_ok("wrap");

    // INCR from an unaligned address realigns on beat 2.
    push_req(12'h00A, 32'h103, 8'd1, 3'd2, 2'b01);
    run(2, -1, 0, -1);
    e_addr = '{32'h103, 32'h104};
    e_id   = '{12'h00A, 12'h00A};
    e_last = '{1'b0, 1'b1};
    check_ok("unaligned");

    // INCR rolling over the top of the address space.
    push_req(12'h00B, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01);
    run(2, -1, 0, -1);
    e_addr = '{32'hFFFF_FFF8, 32'h0};
    e_id   = '{12'h00B, 12'h00B};
    e_last = '{1'b0, 1'b1};
    check_ok("rollover");

    // FIXED with a 5-cycle stall on the first beat.
    push_req(12'h055, 32'h40, 8'd2, 3'd3, 2'b00);
    run(3, 0, 5, -1);
    e_addr = '{32'h40, 32'h40, 32'h40};
    e_id   = '{12'h055, 12'h055, 12'h055};
    e_last = '{1'b0, 1'b0, 1'b1};
    check_ok("fixed");
    chk("fixed_stall_cycles", 64'(st_data.size()), 64'd5);
    for (int i = 0; i < st_data.size(); i++) begin
      chk($sformatf("fixed_stall_rdata%0d", i), st_data[i], pat(32'h40));
      chk($sformatf("fixed_stall_hold%0d", i), 64'({st_valid[i], st_last[i], st_id[i]}),
          64'({1'b1, 1'b0, 12'h055}));
    end

    // Error requests.
    push_req(12'h0E1, 32'h80, 8'd2, 3'd3, 2'b11);
    run(3, -1, 0, -1);
    check_err("err_burst", 12'h0E1);
    push_req(12'h0E2, 32'h80, 8'd2, 3'd4, 2'b01);
    run(3, -1, 0, -1);
    check_err("err_size", 12'h0E2);
    push_req(12'h0E3, 32'h80, 8'd2, 3'd2, 2'b10);
    run(3, -1, 0, -1);
    check_err("err_wraplen", 12'h0E3);

    // Reset asserted while beat 2 of an 8-beat burst is on the bus.
    push_req(12'h0F0, 32'h300, 8'd7, 3'd3, 2'b01);
    run(8, -1, 0, 1);
    #1;
    check_zero("abort");
    chk("abort_beats_before", 64'(b_data.size()), 64'd1);
    chk("abort_mem_before", 64'(m_addr.size()), 64'd2);
    req_q.delete();
    arvalid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid || mem_en) quiet = 0;
    end
    chk("abort_quiet", 64'(quiet), 64'd1);
    push_req(12'h007, 32'h200, 8'd0, 3'd3, 2'b01);
    run(1, -1, 0, -1);
    e_addr = '{32'h200};
    e_id   = '{12'h007};
    e_last = '{1'b1};
    check_ok("post_reset");

    // Back-to-back: second request waits behind the first burst.
    push_req(12'h111, 32'h500, 8'd1, 3'd3, 2'b01);
    push_req(12'h222, 32'h600, 8'd0, 3'd3, 2'b00);
    run(3, -1, 0, -1);
    e_addr = '{32'h500, 32'h508, 32'h600};
    e_id   = '{12'h111, 12'h111, 12'h222};
    e_last = '{1'b0, 1'b1, 1'b1};
    check_ok("b2b");
    chk("b2b_handshakes", 64'(hs_n.size()), 64'd2);
    chk("b2b_second_accept", 64'(hs_n[1] - b_n[1]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
Name: axi_read_slave

Overview:
- AXI4 read-channel responder. It is the read-direction counterpart of the team's write-channel master/slave pair, sitting on the slave side of the AR/R channels.
- Accepts one read-address request at a time and computes per-beat addresses for FIXED, INCR and WRAP bursts.
- Fetches each beat from a synchronous one-cycle-latency memory port and returns it on R with full rready backpressure and correct rlast/rresp.
- Bench pairing: a read master model drives AR and consumes R.

Parameters:
- IDW, 12, ID width.
- AW, 32, address width (byte address).
- DW, 64, data width in bits; must be a power of two, 8..1024.

Ports:
- clk  input  1  global clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_axi_arid  input  IDW  read request ID.
- s_axi_araddr  input  AW  start byte address.
- s_axi_arlen  input  8  beats minus one.
- s_axi_arsize  input  3  log2 bytes per beat.
- s_axi_arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- s_axi_arvalid  input  1  request valid.
- s_axi_arready  output  1  request accepted.
- s_axi_rid  output  IDW  echoes the latched arid.
- s_axi_rdata  output  DW  beat data.
- s_axi_rresp  output  2  00 OKAY, 10 SLVERR.
- s_axi_rlast  output  1  final beat.
- s_axi_rvalid  output  1  beat valid.
- s_axi_rready  input  1  master accepts beat.
- mem_en  output  1  memory read strobe.
- mem_addr  output  AW  memory byte address.
- mem_rdata  input  DW  read data, valid in the cycle after mem_en.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE. All outputs are 0: arready, rvalid, rlast, rresp, rid, rdata, mem_en, mem_addr. Beat counter and latched request are cleared.
- Reset mid-burst aborts the burst silently; no further R beats are issued. The first request after release is handled cleanly.
- arready is registered. It goes to 1 on the first clock edge after reset release while in IDLE. It drops to 0 on the edge that completes an AR handshake, and returns to 1 on the edge that accepts the last R beat.
- A request is accepted only when arvalid and arready are both high in the same cycle. On acceptance, latch arid, araddr, arlen, arsize and arburst; clear the beat counter.
- Error check on acceptance. The request is an error if any of the following holds:
  - arburst = 11;
  - arsize > log2(DW/8);
  - arburst = WRAP with arlen not in {1, 3, 7, 15}.
- States: IDLE -> FETCH -> CAPTURE -> RESP -> (FETCH | IDLE). Error requests go IDLE -> ERR -> IDLE.
- FETCH (1 cycle): mem_en = 1, mem_addr = current beat address. mem_en is 0 in every other state.
- CAPTURE (1 cycle): mem_rdata is registered into rdata at the end of the cycle.
- RESP: rvalid = 1, rresp = 00, rid = latched ID, rlast = 1 when the beat count equals arlen.
  - While rready = 0: rdata, rlast, rid, rresp and rvalid hold stable. No memory access.
  - On rready = 1: advance the address and counter. Go to FETCH if more beats remain, otherwise go to IDLE with rvalid and rlast cleared.
- Latency: AR handshake in cycle C0 -> FETCH in C1 -> rvalid high in C3. With rready held high, beats arrive every 3 cycles. An arlen = N burst occupies 3(N+1) cycles after C0, and arready returns the cycle after the last beat.
- ERR: rvalid = 1, rresp = 10, rdata = 0, no mem_en. One beat per cycle while rready is high, rlast on beat arlen, then IDLE. Exactly arlen+1 beats are returned.
- Address arithmetic (B = 1 << arsize; all arithmetic modulo 2^AW):
  - FIXED: the address stays at araddr for every beat.
  - INCR: next = (addr & ~(B-1)) + B. The first beat uses the unaligned araddr; later beats are aligned.
  - WRAP: L = (arlen+1)*B. next = (addr & ~(L-1)) | ((addr + B) & (L-1)).
  - INCR crossing 2^AW wraps to 0 (4KB-boundary legality is the master's responsibility; no check).
- arvalid asserted while busy is ignored and not latched. The request remains pending until arready returns.

Test Plan:
- INCR, araddr=0x100, arlen=3, arsize=3, rready=1, DW=64 -> mem_addr 0x100, 0x108, 0x110, 0x118; 4 beats, rlast on the 4th only; rresp=00; rvalid first seen 3 cycles after the AR handshake; arready high again the cycle after beat 4.
- WRAP, araddr=0x1C, arlen=3, arsize=2 -> mem_addr 0x1C, 0x10, 0x14, 0x18; rid equals the driven arid=0xABC on every beat.
- FIXED, araddr=0x40, arlen=2, with rready low for 5 cycles on beat 1 -> rdata/rlast/rid held stable; exactly 3 mem_en pulses, all at 0x40; no beat lost or duplicated.
- Error cases, each checked separately: arburst=11, arlen=2; arsize=4 with DW=64; WRAP with arlen=2 -> 3 beats each with rresp=10 and rdata=0, on consecutive cycles; mem_en never asserted.
- resetn pulsed low during beat 2 of an arlen=7 INCR -> all outputs 0 immediately; no further beats; next request arlen=0 at 0x200 returns a single beat with rlast=1 from 0x200.
- Back-to-back requests: arvalid held high with a second request queued -> second request accepted only after the first burst's rlast handshake; ordering and IDs preserved.
